config_port_arbiter: RTL
========================

Name: config_port_arbiter

Overview:
- Parametrised successor to the fixed three-way configuration-source mux in the fabric config path.
- Arbitrates NUM_SRC configuration sources (e.g. self-write, bitbang, UART, JTAG) by fixed priority, with the highest index winning.
- Locks the grant for a whole session and buffers words in a FIFO so the downstream ConfigFSM can apply backpressure.
- Generates a one-cycle FSM_Reset pulse per session and a stretched activity LED.

Parameters:
- NUM_SRC, 4, number of configuration sources; index NUM_SRC-1 has highest priority.
- DATA_WIDTH, 32, configuration word width.
- FIFO_DEPTH, 4, buffer depth in words; must be a power of 2, at least 2.
- LED_STRETCH, 16, cycles ReceiveLED stays high after the last output strobe; at least 1.

Ports:
- CLK  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- SrcActive  in  NUM_SRC  per-source session-active flag.
- SrcWriteData  in  NUM_SRC*DATA_WIDTH  per-source word; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- SrcWriteStrobe  in  NUM_SRC  per-source one-cycle word-valid.
- ConfigReady  in  1  downstream can accept a word this cycle.
- ConfigWriteData  out  DATA_WIDTH  word to ConfigFSM; registered.
- ConfigWriteStrobe  out  1  word valid; registered, one cycle per word.
- FSM_Reset  out  1  one-cycle pulse at session start; registered.
- GrantValid  out  1  a source currently holds the grant.
- GrantIdx  out  clog2(NUM_SRC), min 1  index of the granted source; 0 when GrantValid=0.
- ReceiveLED  out  1  stretched activity indicator.
- Overflow  out  1  sticky: a granted word was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, sampled at CLK edge):
  - State goes to IDLE and the FIFO is flushed.
  - All outputs are 0: ConfigWriteData=0, GrantIdx=0; Overflow and the LED counter are cleared.
  - Reset mid-session discards buffered words; no strobe is emitted after reset.
- State machine (IDLE, GRANT, DRAIN):
  - IDLE: if any SrcActive=1, latch the highest active index into GrantIdx, go to GRANT and pulse FSM_Reset in the first GRANT cycle. Otherwise stay.
  - GRANT: only the granted source's strobes are accepted; strobes from all other sources are ignored. When SrcActive[GrantIdx] falls, go to DRAIN.
  - DRAIN: no pushes. When the FIFO is empty and ConfigWriteStrobe is low, go to IDLE. IDLE then re-arbitrates on the next edge, so there is at least one IDLE cycle between sessions.
  - GrantValid=1 in GRANT and DRAIN.
- FIFO:
  - Push: state is GRANT, SrcWriteStrobe[GrantIdx]=1, and (not full, or a pop happens the same cycle).
  - Full with no pop: the word is dropped and Overflow is set to 1 until reset.
  - Pop: FIFO not empty and ConfigReady=1. The popped word is registered into ConfigWriteData, with ConfigWriteStrobe=1 the next cycle.
  - No bypass: a word pushed at edge k pops at the earliest at edge k+1, so ConfigWriteStrobe is high in the cycle after edge k+1 (latency 2).
  - ConfigWriteData holds its last value when the strobe is low.
  - Read and write pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a log2(FIFO_DEPTH)+1-bit count.
- Ordering: the FSM_Reset pulse always precedes the session's first ConfigWriteStrobe by at least 2 cycles.
- ReceiveLED:
  - The counter reloads to LED_STRETCH on each ConfigWriteStrobe, otherwise decrements to 0 and stops.
  - ReceiveLED = (counter != 0).
- Simultaneous events:
  - Push and pop in the same cycle leave the count unchanged.
  - A strobe in the same cycle that SrcActive falls is still accepted, because the state is still GRANT.

Optional Feature:
- Macro: CONFIG_ARB_PREEMPT_EN.
- Defined: in GRANT, if any SrcActive[j]=1 with j > GrantIdx, go to DRAIN immediately. Further strobes from the old source are ignored. After the drain, IDLE grants j with a new FSM_Reset pulse.
- Undefined: the grant is held until SrcActive[GrantIdx] falls; higher-priority requests wait.

Test Plan:
- Reset with SrcActive[1]=1 and 3 words buffered -> next cycle GrantValid=0, ConfigWriteStrobe=0, FIFO empty, Overflow=0, ReceiveLED=0.
- SrcActive[2]=1 then a strobe with 0xA5A5_0001, ConfigReady=1 -> FSM_Reset pulses 1 cycle, GrantIdx=2, ConfigWriteStrobe with 0xA5A5_0001 exactly 2 cycles after the strobe, ReceiveLED high 16 cycles after it.
- SrcActive[0] and [3] rise together -> GrantIdx=3; strobes on source 0 produce no output.
- ConfigReady=0, FIFO_DEPTH=4, 6 strobes 0x1..0x6 -> Overflow=1; after ConfigReady=1, exactly 0x1..0x4 are emitted in order.
- Source 1 drops SrcActive with 2 words buffered and ConfigReady=1 -> DRAIN emits both words, then IDLE, then GrantValid=0.
- With CONFIG_ARB_PREEMPT_EN: source 1 granted, source 3 rises -> source 1 drains, a second FSM_Reset pulse occurs, GrantIdx=3. Without the macro: source 3 waits until source 1 deasserts.

Source files
------------

// File: rtl/config_port_arbiter.sv
// Fixed-priority configuration-source arbiter: session-locked grant, word FIFO, FSM_Reset pulse, activity LED.
// Optional pre-emption by a higher-priority source is enabled by defining CONFIG_ARB_PREEMPT_EN.
module config_port_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int LED_STRETCH = 16,
  localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            SrcActive,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] SrcWriteData,
  input  logic [NUM_SRC-1:0]            SrcWriteStrobe,
  input  logic                          ConfigReady,
  output logic [DATA_WIDTH-1:0]         ConfigWriteData,
  output logic                          ConfigWriteStrobe,
  output logic                          FSM_Reset,
  output logic                          GrantValid,
  output logic [IDX_W-1:0]              GrantIdx,
  output logic                          ReceiveLED,
  output logic                          Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LED_W = $clog2(LED_STRETCH + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        req_idx;
  logic                    req_any;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    empty;
  logic                    full;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   granted_data;
  logic [LED_W-1:0]        led_cnt;

  // Ascending scan so the highest active index is the one left in req_idx.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SrcActive[i]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
  end

`ifdef CONFIG_ARB_PREEMPT_EN
  logic higher_req;

  always_comb begin
    higher_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SrcActive[i] && (IDX_W'(i) > grant_idx)) higher_req = 1'b1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_any) state_next = GRANT;
      end
      GRANT: begin
        if (!SrcActive[grant_idx]) state_next = DRAIN;
`ifdef CONFIG_ARB_PREEMPT_EN
        if (higher_req) state_next = DRAIN;
`endif
      end
      DRAIN: begin
        if (empty && !ConfigWriteStrobe) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // grant_idx is cleared on the way back to IDLE so GrantIdx reads 0 whenever no grant is held.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      FSM_Reset <= 1'b0;
    end else begin
      state     <= state_next;
      FSM_Reset <= (state == IDLE) && req_any;
      if ((state == IDLE) && req_any) begin
        grant_idx <= req_idx;
      end else if (state_next == IDLE) begin
        grant_idx <= '0;
      end
    end
  end

  assign granted_data = SrcWriteData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign pop          = !empty && ConfigReady;
  assign accept       = (state == GRANT) && SrcWriteStrobe[grant_idx];
  assign push         = accept && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= granted_data;
  end

  // A push while full is only allowed alongside a pop; the pop reads the old slot contents first.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      ConfigWriteData   <= '0;
      ConfigWriteStrobe <= 1'b0;
      Overflow          <= 1'b0;
    end else begin
      ConfigWriteStrobe <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        ConfigWriteData <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (accept && !push) Overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      led_cnt <= '0;
    end else if (ConfigWriteStrobe) begin
      led_cnt <= LED_W'(LED_STRETCH);
    end else if (led_cnt != '0) begin
      led_cnt <= led_cnt - 1'b1;
    end
  end

  assign ReceiveLED = (led_cnt != '0);
  assign GrantValid = (state != IDLE);
  assign GrantIdx   = grant_idx;

endmodule
